sprite_draw_sequencer: RTL and testbench

Downstream consumer of the per-sprite drawer blocks (boss bullets, player, enemies) in the 160x120, 3-bit-colour VGA shooter. On each frame tick it optionally clears the screen. It then runs each drawer client in turn over the start/done handshake. It muxes the active client's x/y/color/wren onto the single VGA adapter write port.

---
 rtl/sprite_draw_sequencer_pkg.sv | 27 ++
 rtl/sprite_draw_sequencer_screen_clear_raster.sv | 31 +++
 rtl/sprite_draw_sequencer.sv | 179 +++++++++++++++++
 tb/tb_sprite_draw_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_draw_sequencer_pkg.sv
// Shared screen geometry, colour constants and sequencer state encoding
// for the sprite drawing pipeline of the 160x120 VGA shooter.
package sprite_draw_sequencer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOR_W  = 3;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  localparam logic [COLOR_W-1:0] BG_BLACK = 3'b000;
  localparam logic [COLOR_W-1:0] BG_BLUE  = 3'b001;
  localparam logic [COLOR_W-1:0] BG_WHITE = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_START,
    ST_WAIT,
    ST_RELEASE,
    ST_NEXT
  } seq_state_t;

endpackage

// File: rtl/sprite_draw_sequencer_screen_clear_raster.sv
// Full-screen raster walker: x runs fastest, wraps back to (0,0) after the
// last pixel so the next fill starts clean without an explicit restart.
module screen_clear_raster
  import sprite_draw_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic           en,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic           last
);

  assign last = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk) begin
    if (!resetn || start) begin
      cx <= '0;
      cy <= '0;
    end else if (en) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= last ? '0 : cy + Y_W'(1);
      end else begin
        cx <= cx + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Per-frame draw sequencer: optional background clear, then each drawer
// client in turn over start/done, muxed onto the single VGA write port.
//
// state   | meaning
// IDLE    | waiting for frame_tick
// CLEAR   | background fill, one pixel per cycle
// START   | raise start for client idx, clear timeout counter
// WAIT    | forward client idx pixels until done or timeout
// RELEASE | start dropped, waiting for done to fall (bounded)
// NEXT    | advance to next client or finish the frame
module sprite_draw_sequencer
  import sprite_draw_sequencer_pkg::*;
#(
  parameter int                 N_CLIENTS = 4,
  parameter bit                 CLEAR_EN  = 1'b1,
  parameter logic [COLOR_W-1:0] BG_COLOR  = BG_BLACK,
  parameter int                 TIMEOUT   = 1023
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         frame_tick,
  output logic [N_CLIENTS-1:0]         client_start,
  input  logic [N_CLIENTS-1:0]         client_done,
  input  logic [X_W*N_CLIENTS-1:0]     client_x,
  input  logic [Y_W*N_CLIENTS-1:0]     client_y,
  input  logic [COLOR_W*N_CLIENTS-1:0] client_color,
  input  logic [N_CLIENTS-1:0]         client_wren,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOR_W-1:0]           vga_color,
  output logic                         vga_plot,
  output logic                         busy,
  output logic                         overrun,
  output logic [N_CLIENTS-1:0]         fault
);

  localparam int IDX_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_CLIENTS - 1);
  localparam logic [CNT_W-1:0] CNT_TO   = CNT_W'(TIMEOUT);

  seq_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_CLIENTS-1:0]   fault_d;
  logic                   overrun_d;
  logic [X_W-1:0]         vga_x_d;
  logic [Y_W-1:0]         vga_y_d;
  logic [COLOR_W-1:0]     vga_color_d;
  logic                   vga_plot_d;
  logic                   clr_start, clr_en, clr_last;
  logic [X_W-1:0]         clr_x;
  logic [Y_W-1:0]         clr_y;

  logic [X_W-1:0]     x_arr   [N_CLIENTS];
  logic [Y_W-1:0]     y_arr   [N_CLIENTS];
  logic [COLOR_W-1:0] col_arr [N_CLIENTS];

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_unpack
    assign x_arr[g]   = client_x[X_W*g +: X_W];
    assign y_arr[g]   = client_y[Y_W*g +: Y_W];
    assign col_arr[g] = client_color[COLOR_W*g +: COLOR_W];
  end

  screen_clear_raster u_clear (
    .clk    (clk),
    .resetn (resetn),
    .start  (clr_start),
    .en     (clr_en),
    .cx     (clr_x),
    .cy     (clr_y),
    .last   (clr_last)
  );

  // Start is decoded from state so a reset drops it on the same edge.
  assign client_start = ((state_q == ST_START) || (state_q == ST_WAIT)) ?
                        (N_CLIENTS'(1) << idx_q) : '0;
  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      fault     <= '0;
      overrun   <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      fault     <= fault_d;
      overrun   <= overrun_d;
      vga_x     <= vga_x_d;
      vga_y     <= vga_y_d;
      vga_color <= vga_color_d;
      vga_plot  <= vga_plot_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    fault_d     = fault;
    overrun_d   = overrun || (frame_tick && (state_q != ST_IDLE));
    vga_x_d     = vga_x;
    vga_y_d     = vga_y;
    vga_color_d = vga_color;
    vga_plot_d  = 1'b0;
    clr_start   = 1'b0;
    clr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          idx_d = '0;
          cnt_d = '0;
          if (CLEAR_EN) begin
            clr_start = 1'b1;
            state_d   = ST_CLEAR;
          end else begin
            state_d = ST_START;
          end
        end
      end
      ST_CLEAR: begin
        clr_en      = 1'b1;
        vga_x_d     = clr_x;
        vga_y_d     = clr_y;
        vga_color_d = BG_COLOR;
        vga_plot_d  = 1'b1;
        if (clr_last) state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        vga_x_d     = x_arr[idx_q];
        vga_y_d     = y_arr[idx_q];
        vga_color_d = col_arr[idx_q];
        vga_plot_d  = client_wren[idx_q];
        if (client_done[idx_q]) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == CNT_TO) begin
          fault_d[idx_q] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (!client_done[idx_q]) begin
          state_d = ST_NEXT;
        end else if (cnt_q == CNT_TO) begin
          fault_d[idx_q] = 1'b1;
          state_d        = ST_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_START;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: reactive client models, a pixel
// scoreboard built from client scripts, and a separate clear-pass instance.
module tb_sprite_draw_sequencer;

  localparam int N  = 4;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        resetn;
  logic        frame_tick;
  logic [3:0]  client_start, client_done, client_wren, fault;
  logic [31:0] client_x;
  logic [27:0] client_y;
  logic [11:0] client_color;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_color;
  logic        vga_plot, busy, overrun;

  logic        tick_c;
  logic [1:0]  start_c, done_c, wren_c, fault_c;
  logic [15:0] x_c;
  logic [13:0] y_c;
  logic [5:0]  col_c;
  logic [7:0]  vga_x_c;
  logic [6:0]  vga_y_c;
  logic [2:0]  vga_color_c;
  logic        vga_plot_c, busy_c, overrun_c;

  always #5 clk = ~clk;

  sprite_draw_sequencer #(.N_CLIENTS(N), .CLEAR_EN(1'b0), .BG_COLOR(3'b000), .TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick),
    .client_start(client_start), .client_done(client_done),
    .client_x(client_x), .client_y(client_y), .client_color(client_color),
    .client_wren(client_wren), .vga_x(vga_x), .vga_y(vga_y),
    .vga_color(vga_color), .vga_plot(vga_plot), .busy(busy),
    .overrun(overrun), .fault(fault));

  sprite_draw_sequencer #(.N_CLIENTS(2), .CLEAR_EN(1'b1), .BG_COLOR(3'b000), .TIMEOUT(1023)) dut_clr (
    .clk(clk), .resetn(resetn), .frame_tick(tick_c),
    .client_start(start_c), .client_done(done_c),
    .client_x(x_c), .client_y(y_c), .client_color(col_c),
    .client_wren(wren_c), .vga_x(vga_x_c), .vga_y(vga_y_c),
    .vga_color(vga_color_c), .vga_plot(vga_plot_c), .busy(busy_c),
    .overrun(overrun_c), .fault(fault_c));

  int checks = 0;
  int errors = 0;
  int cycnum = 0;
  always @(posedge clk) cycnum++;

  // Client scripts: done_dly 0 means the client never finishes.
  int          done_dly [N];
  int          lag      [N];
  logic [17:0] pix      [N][32];
  bit          mask     [N][32];
  bit          noise;
  int          cyc      [N];
  int          relcnt   [N];
  int          wr_cycle0;
  logic [3:0]  exp_fault;
  logic        exp_overrun;

  initial begin
    client_done = '0; client_wren = '0;
    client_x = '0; client_y = '0; client_color = '0;
    for (int i = 0; i < N; i++) begin cyc[i] = 0; relcnt[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        logic        w;
        logic [17:0] p;
        w = 1'b0;
        p = 18'($urandom);
        if (client_start[i]) begin
          cyc[i]++;
          relcnt[i] = 0;
          client_done[i] = (done_dly[i] != 0) && (cyc[i] >= done_dly[i]);
          if (cyc[i] >= 2 && cyc[i] <= done_dly[i] && cyc[i] < 32 && mask[i][cyc[i]]) begin
            w = 1'b1;
            p = pix[i][cyc[i]];
            if (i == 0) wr_cycle0 = cycnum;
          end
        end else begin
          if (cyc[i] != 0 && done_dly[i] != 0 && cyc[i] >= done_dly[i] && relcnt[i] < lag[i]) begin
            client_done[i] = 1'b1;
            relcnt[i]++;
          end else begin
            client_done[i] = 1'b0;
            cyc[i] = 0;
            relcnt[i] = 0;
          end
          if (noise) w = 1'($urandom);
        end
        client_wren[i] = w;
        client_x[8*i +: 8] = p[17:10];
        client_y[7*i +: 7] = p[9:3];
        client_color[3*i +: 3] = p[2:0];
      end
    end
  end

  int ccyc [2];
  initial begin
    done_c = '0; wren_c = '0;
    x_c = 16'h5a3c; y_c = 14'h1234; col_c = 6'b101_011;
    ccyc[0] = 0; ccyc[1] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (start_c[i]) begin ccyc[i]++; done_c[i] = (ccyc[i] >= 3); end
        else begin ccyc[i] = 0; done_c[i] = 1'b0; end
      end
    end
  end

  logic [17:0] obs_q [$];
  int          obs_cyc [$];
  int          hi_cnt [N];
  int          onehot_viol;

  always @(negedge clk) begin
    if (vga_plot) begin
      obs_q.push_back({vga_x, vga_y, vga_color});
      obs_cyc.push_back(cycnum);
    end
    for (int i = 0; i < N; i++) if (client_start[i]) hi_cnt[i]++;
    if ($countones(client_start) > 1) onehot_viol++;
  end

  task automatic run_frame(input string name, input int extra_tick);
    logic [17:0] exp_q [$];
    int          exp_hi [N];
    int          k;
    bit          timed_out;
    obs_q.delete();
    obs_cyc.delete();
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    onehot_viol = 0;
    for (int i = 0; i < N; i++) begin
      if (done_dly[i] == 0) begin
        exp_fault[i] = 1'b1;
        exp_hi[i] = TO + 2;
      end else begin
        exp_hi[i] = done_dly[i];
        for (int c = 2; c <= done_dly[i] && c < 32; c++)
          if (mask[i][c]) exp_q.push_back(pix[i][c]);
      end
    end
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_start: got %b expected 1", name, busy); end
    k = 0;
    timed_out = 1'b1;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      frame_tick = (k == extra_tick) && busy;
      if (frame_tick) exp_overrun = 1'b1;
      if (!busy) begin timed_out = 1'b0; break; end
    end
    frame_tick = 1'b0;
    checks++;
    if (timed_out) begin errors++; $display("FAIL %s frame_end: busy still 1 after %0d cycles", name, k); end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s plot_count: got %0d expected %0d", name, obs_q.size(), exp_q.size());
    end else begin
      int bad;
      bad = -1;
      for (int j = 0; j < exp_q.size(); j++) if (bad < 0 && obs_q[j] !== exp_q[j]) bad = j;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s pixel[%0d]: got %h expected %h", name, bad, obs_q[bad], exp_q[bad]);
      end
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (hi_cnt[i] != exp_hi[i]) begin
        errors++;
        $display("FAIL %s start_len[%0d]: got %0d expected %0d", name, i, hi_cnt[i], exp_hi[i]);
      end
    end
    checks++;
    if (fault !== exp_fault) begin errors++; $display("FAIL %s fault: got %b expected %b", name, fault, exp_fault); end
    checks++;
    if (overrun !== exp_overrun) begin errors++; $display("FAIL %s overrun: got %b expected %b", name, overrun, exp_overrun); end
    checks++;
    if (onehot_viol != 0) begin errors++; $display("FAIL %s start_onehot: got %0d multi-hot cycles expected 0", name, onehot_viol); end
  endtask

  task automatic set_clients(input int d0, input int d1, input int d2, input int d3);
    done_dly[0] = d0; done_dly[1] = d1; done_dly[2] = d2; done_dly[3] = d3;
    for (int i = 0; i < N; i++) begin
      lag[i] = 0;
      for (int c = 0; c < 32; c++) begin mask[i][c] = 1'b0; pix[i][c] = 18'($urandom); end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    tick_c = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({client_start, vga_plot, busy, overrun, fault} !== 11'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got start=%b plot=%b busy=%b ovr=%b fault=%b expected all 0",
               client_start, vga_plot, busy, overrun, fault);
    end
    checks++;
    if ({vga_x, vga_y, vga_color} !== 18'b0) begin
      errors++;
      $display("FAIL reset_pixel: got %h expected 0", {vga_x, vga_y, vga_color});
    end
    resetn = 1'b1;
    exp_fault = '0;
    exp_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_pixel();
    set_clients(3, 2, 2, 2);
    mask[0][2] = 1'b1;
    pix[0][2] = {8'd20, 7'd100, 3'b101};
    run_frame("single_pixel", 0);
    checks++;
    if (obs_cyc.size() != 1 || obs_cyc[0] != wr_cycle0 + 1) begin
      errors++;
      $display("FAIL plot_latency: got %0d plots, first at cycle %0d expected one at %0d",
               obs_cyc.size(), (obs_cyc.size() > 0) ? obs_cyc[0] : -1, wr_cycle0 + 1);
    end
  endtask

  task automatic test_isolation();
    set_clients(8, 5, 4, 3);
    for (int i = 0; i < N; i++)
      for (int c = 2; c < 9; c++) mask[i][c] = 1'($urandom);
    noise = 1'b1;
    run_frame("isolation", 0);
  endtask

  task automatic test_timeout();
    set_clients(3, 4, 0, 2);
    mask[3][2] = 1'b1;
    noise = 1'b0;
    run_frame("timeout", 0);
  endtask

  task automatic test_overrun();
    set_clients(6, 6, 6, 6);
    run_frame("overrun", 5);
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL overrun_no_restart: got busy=%b expected 0", busy); end
    set_clients(2, 3, 2, 3);
    mask[1][3] = 1'b1;
    run_frame("after_overrun", 0);
  endtask

  task automatic test_reset_mid_frame();
    int k;
    set_clients(3, 0, 3, 3);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    while (!client_start[1] && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (!client_start[1]) begin errors++; $display("FAIL reset_mid_reach: got start=%b expected client 1 active", client_start); end
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({client_start, vga_plot, busy, overrun, fault} !== 11'b0) begin
      errors++;
      $display("FAIL reset_mid: got start=%b plot=%b busy=%b ovr=%b fault=%b expected all 0",
               client_start, vga_plot, busy, overrun, fault);
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_fault = '0;
    exp_overrun = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    noise = 1'b1;
    for (int f = 0; f < 4; f++) begin
      set_clients($urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12), $urandom_range(2, 12));
      for (int i = 0; i < N; i++) begin
        lag[i] = $urandom_range(0, 4);
        for (int c = 0; c < 32; c++) mask[i][c] = 1'($urandom);
      end
      run_frame($sformatf("random%0d", f), 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_clear();
    int          k, mism;
    bit          fin, saw1;
    logic [17:0] got, expv, first_px, last_px;
    k = 0; mism = 0; fin = 1'b0; saw1 = 1'b0;
    first_px = '1; last_px = '1;
    tick_c = 1'b1;
    @(negedge clk);
    tick_c = 1'b0;
    for (int n = 0; n < 25000; n++) begin
      if (vga_plot_c) begin
        got = {vga_x_c, vga_y_c, vga_color_c};
        expv = {8'(k % 160), 7'(k / 160), 3'b000};
        if (got !== expv) begin
          if (mism == 0) $display("FAIL clear_raster[%0d]: got %h expected %h", k, got, expv);
          mism++;
        end
        if (k == 0) first_px = got;
        last_px = got;
        k++;
      end
      if (start_c[1]) saw1 = 1'b1;
      if (!busy_c) begin fin = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (k != 19200) begin errors++; $display("FAIL clear_count: got %0d expected 19200", k); end
    checks++;
    if (first_px !== 18'b0) begin errors++; $display("FAIL clear_first: got %h expected 0", first_px); end
    checks++;
    if (last_px !== {8'd159, 7'd119, 3'b000}) begin
      errors++;
      $display("FAIL clear_last: got %h expected %h", last_px, {8'd159, 7'd119, 3'b000});
    end
    checks++;
    if (mism != 0) begin errors++; $display("FAIL clear_order: got %0d bad pixels expected 0", mism); end
    checks++;
    if (!fin || !saw1) begin errors++; $display("FAIL clear_frame_end: got finished=%b client1_seen=%b expected 1 1", fin, saw1); end
    checks++;
    if (fault_c !== 2'b00 || overrun_c !== 1'b0) begin
      errors++;
      $display("FAIL clear_flags: got fault=%b ovr=%b expected 00 0", fault_c, overrun_c);
    end
  endtask

  initial begin
    noise = 1'b0;
    wr_cycle0 = -100;
    for (int i = 0; i < N; i++) begin done_dly[i] = 2; lag[i] = 0; end
    test_reset();
    test_single_pixel();
    test_isolation();
    test_timeout();
    test_overrun();
    test_reset_mid_frame();
    test_random_frames();
    test_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
